usb_reg_responder: RTL



---
 rtl/usb_reg_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/usb_reg_responder.sv
// usb_reg_responder: responder for the SAM3U parallel external bus.
// Synchronises the bus pins, detects read/write strobe edges, issues
// single-cycle register-bus requests with a per-address byte counter,
// and returns read data with an explicit output enable for the pad tristate.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | waiting for a write or read start edge
// ST_WRITE    | write accepted, waiting for wrn/cen to return high
// ST_RD_WAIT  | read issued, counting down to the reg_datai capture edge
// ST_RD_DRIVE | read data captured and driven until rdn/cen return high
module usb_reg_responder #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pRD_LATENCY   = 2
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic [7:0]               usb_addr,
  input  logic [7:0]               usb_din,
  input  logic                     usb_rdn,
  input  logic                     usb_wrn,
  input  logic                     usb_cen,
  output logic [7:0]               usb_dout,
  output logic                     usb_isout,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_write,
  output logic                     reg_read,
  output logic                     err_both
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_DRIVE = 2'd3
  } state_t;

  // Down-counter reload: terminal count (0) is reached on the capture edge.
  localparam logic [1:0] LP_LAT_LOAD = 2'(pRD_LATENCY - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_s1_addr;
  logic [7:0] r_s1_din;
  logic       r_s1_rdn;
  logic       r_s1_wrn;
  logic       r_s1_cen;
  logic       r_s2_rdn;
  logic       r_s2_wrn;
  logic       r_s1_vld;
  logic       r_s2_vld;
  logic [1:0] r_lat_cnt;
  logic       r_rd_abort;
  logic       r_have_prev;

  logic w_wr_start;
  logic w_rd_start;
  logic w_wr_release;
  logic w_rd_release;
  logic w_lat_tc;
  logic w_acc_wr;
  logic w_acc_rd;
  logic w_capture;
  logic w_same_addr;

  // Two-stage input capture; valid bits keep the reset value of s2 from
  // looking like an idle-high sample, so a strobe held low through reset
  // release never produces a start edge.
  always_ff @(posedge clk_usb) begin
    if (!reset_n) begin
      r_s1_addr <= 8'h00;
      r_s1_din  <= 8'h00;
      r_s1_rdn  <= 1'b1;
      r_s1_wrn  <= 1'b1;
      r_s1_cen  <= 1'b1;
      r_s2_rdn  <= 1'b1;
      r_s2_wrn  <= 1'b1;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
    end else begin
      r_s1_addr <= usb_addr;
      r_s1_din  <= usb_din;
      r_s1_rdn  <= usb_rdn;
      r_s1_wrn  <= usb_wrn;
      r_s1_cen  <= usb_cen;
      r_s2_rdn  <= r_s1_rdn;
      r_s2_wrn  <= r_s1_wrn;
      r_s1_vld  <= 1'b1;
      r_s2_vld  <= r_s1_vld;
    end
  end

  assign w_wr_start   = r_s2_vld & ~r_s1_wrn & r_s2_wrn & ~r_s1_cen;
  assign w_rd_start   = r_s2_vld & ~r_s1_rdn & r_s2_rdn & ~r_s1_cen;
  assign w_wr_release = r_s1_wrn | r_s1_cen;
  assign w_rd_release = r_s1_rdn | r_s1_cen;
  assign w_lat_tc     = (r_lat_cnt == 2'd0);
  assign w_same_addr  = r_have_prev & (r_s1_addr == reg_address);
  assign usb_isout    = (r_state == ST_RD_DRIVE);

  // State register.
  always_ff @(posedge clk_usb) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; start edges are only honoured in IDLE, write wins a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_wr    = 1'b0;
    w_acc_rd    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_start) begin
          w_state_nxt = ST_WRITE;
          w_acc_wr    = 1'b1;
        end else if (w_rd_start) begin
          w_state_nxt = ST_RD_WAIT;
          w_acc_rd    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_wr_release) w_state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (w_lat_tc) begin
          w_capture   = 1'b1;
          // A host that let go early still gets the capture, but no drive.
          w_state_nxt = (r_rd_abort | w_rd_release) ? ST_IDLE : ST_RD_DRIVE;
        end
      end
      ST_RD_DRIVE: begin
        if (w_rd_release) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request pulses, latched request fields, byte counter, read capture.
  always_ff @(posedge clk_usb) begin
    if (!reset_n) begin
      reg_write   <= 1'b0;
      reg_read    <= 1'b0;
      reg_address <= 8'h00;
      reg_datao   <= 8'h00;
      reg_bytecnt <= '0;
      usb_dout    <= 8'h00;
      err_both    <= 1'b0;
      r_have_prev <= 1'b0;
      r_lat_cnt   <= 2'd0;
      r_rd_abort  <= 1'b0;
    end else begin
      reg_write <= w_acc_wr;
      reg_read  <= w_acc_rd;
      if (w_acc_wr | w_acc_rd) begin
        reg_address <= r_s1_addr;
        reg_bytecnt <= w_same_addr ? reg_bytecnt + 1'b1 : '0;
        r_have_prev <= 1'b1;
      end
      if (w_acc_wr) reg_datao <= r_s1_din;
      if (w_acc_wr & w_rd_start) err_both <= 1'b1;
      if (w_acc_rd) begin
        r_lat_cnt  <= LP_LAT_LOAD;
        r_rd_abort <= 1'b0;
      end else if (r_state == ST_RD_WAIT) begin
        if (!w_lat_tc) r_lat_cnt <= r_lat_cnt - 2'd1;
        if (w_rd_release) r_rd_abort <= 1'b1;
      end
      if (w_capture) usb_dout <= reg_datai;
    end
  end

endmodule
